// File: rtl/deser_frame_ctrl.sv
// Frame sequencer and nibble-to-word assembler for the ear-EEG deserializer; DESER_SEQ_TAG_EN adds a 4-bit word sequence tag.
// word_valid rises one cycle after the last-nibble capture; a word completing while an unaccepted word is held is dropped and sets sticky overrun.
module deser_frame_ctrl #(
  parameter int NIBBLES_PER_WORD = 4,
  parameter int FRAME_LEN        = 16,
  parameter int GAP_CYCLES       = 2
) (
  input  logic                          data_clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [3:0]                    de_out,
  input  logic                          out_ready,
  input  logic                          clear_ovr,
  output logic                          read,
  output logic [4*NIBBLES_PER_WORD-1:0] word_out,
  output logic                          word_valid,
  output logic                          overrun,
  output logic                          busy,
  output logic [3:0]                    word_tag
);
  localparam int W     = 4 * NIBBLES_PER_WORD;
  localparam int NIB_W = (NIBBLES_PER_WORD > 1) ? $clog2(NIBBLES_PER_WORD) : 1;
  localparam logic [NIB_W-1:0] NIB_LAST  = NIB_W'(NIBBLES_PER_WORD - 1);
  localparam logic [7:0]       SLOT_LAST = 8'(FRAME_LEN - 1);
  localparam logic [7:0]       GAP_LAST  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [7:0]       slot_q, slot_d;
  logic [NIB_W-1:0] nib_idx_q, nib_idx_d;
  logic [W-1:0]     partial_q, partial_d;
  logic [W-1:0]     word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [W-1:0]     word_new;
  logic             capture, word_done, load, drop;

  // The slot counter doubles as the gap counter; both restart from 0.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    unique case (state_q)
      IDLE: if (enable) state_d = START;
      START: begin
        state_d = SHIFT;
        slot_d  = '0;
      end
      SHIFT: begin
        if (slot_q == SLOT_LAST) begin
          slot_d  = '0;
          state_d = (GAP_CYCLES > 0) ? GAP : (enable ? START : IDLE);
        end else begin
          slot_d = slot_q + 8'd1;
        end
      end
      GAP: begin
        if (slot_q == GAP_LAST) begin
          slot_d  = '0;
          state_d = enable ? START : IDLE;
        end else begin
          slot_d = slot_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign capture = (state_q == SHIFT) && (slot_q == SLOT_LAST);

  always_comb begin
    partial_d = partial_q;
    nib_idx_d = nib_idx_q;
    word_done = 1'b0;
    word_new  = partial_q;
    for (int i = 0; i < NIBBLES_PER_WORD; i++) begin
      if (nib_idx_q == NIB_W'(i)) word_new[4*(NIBBLES_PER_WORD-1-i) +: 4] = de_out;
    end
    if (capture) begin
      if (nib_idx_q == NIB_LAST) begin
        word_done = 1'b1;
        nib_idx_d = '0;
        partial_d = '0;
      end else begin
        nib_idx_d = nib_idx_q + NIB_W'(1);
        partial_d = word_new;
      end
    end
  end

  assign load = word_done && (!valid_q || out_ready);
  assign drop = word_done && valid_q && !out_ready;

  always_comb begin
    word_d  = load ? word_new : word_q;
    valid_d = valid_q;
    if (load)                      valid_d = 1'b1;
    else if (valid_q && out_ready) valid_d = 1'b0;
    ovr_d = ovr_q;
    if (drop)           ovr_d = 1'b1;
    else if (clear_ovr) ovr_d = 1'b0;
  end

  always_ff @(posedge data_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      nib_idx_q <= '0;
      partial_q <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      nib_idx_q <= nib_idx_d;
      partial_q <= partial_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef DESER_SEQ_TAG_EN
  logic [3:0] tag_cnt_q;
  logic [3:0] tag_q;

  always_ff @(posedge data_clk) begin
    if (rst) begin
      tag_cnt_q <= '0;
      tag_q     <= '0;
    end else if (load) begin
      tag_q     <= tag_cnt_q;
      tag_cnt_q <= tag_cnt_q + 4'd1;
    end
  end

  assign word_tag = tag_q;
`else
  assign word_tag = 4'h0;
`endif

  assign read       = (state_q == START);
  assign busy       = (state_q != IDLE);
  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_deser_frame_ctrl.sv
// Randomized bench for deser_frame_ctrl against a frame-phase / nibble-queue reference model.
module tb_deser_frame_ctrl;
  localparam int N   = 4;
  localparam int FL  = 16;
  localparam int GAP = 2;
  localparam int W   = 4 * N;

  logic         data_clk = 1'b0;
  logic         rst = 1'b1, enable = 1'b0, out_ready = 1'b0, clear_ovr = 1'b0;
  logic [3:0]   de_out = 4'h0;
  logic         read, word_valid, overrun, busy;
  logic [W-1:0] word_out;
  logic [3:0]   word_tag;

  deser_frame_ctrl #(.NIBBLES_PER_WORD(N), .FRAME_LEN(FL), .GAP_CYCLES(GAP)) dut (
    .data_clk(data_clk), .rst(rst), .enable(enable), .de_out(de_out),
    .out_ready(out_ready), .clear_ovr(clear_ovr), .read(read), .word_out(word_out),
    .word_valid(word_valid), .overrun(overrun), .busy(busy), .word_tag(word_tag)
  );

  always #5 data_clk = ~data_clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: frame position as an integer phase (0 = read cycle,
  // FL = sample slot, FL+GAP = last cycle of the frame) plus a nibble queue.
  bit           m_run;
  int           m_phase;
  logic [3:0]   m_nibs[$];
  logic [W-1:0] m_word;
  bit           m_vld, m_ovr;
  logic [3:0]   m_tag, m_tag_cnt;

  task automatic model_step(input bit en, input logic [3:0] de, input bit rdy,
                            input bit clr, input bit r);
    bit complete, drop;
    logic [W-1:0] w;
    if (r) begin
      m_run = 0; m_phase = 0; m_nibs.delete(); m_word = '0;
      m_vld = 0; m_ovr = 0; m_tag = 0; m_tag_cnt = 0;
      return;
    end
    complete = 0;
    w = '0;
    if (m_run && m_phase == FL) begin
      m_nibs.push_back(de);
      if (m_nibs.size() == N) begin
        foreach (m_nibs[i]) w = {w[W-5:0], m_nibs[i]};
        m_nibs.delete();
        complete = 1;
      end
    end
    drop = complete && m_vld && !rdy;
    if (complete && !drop) begin
      m_word = w; m_vld = 1; m_tag = m_tag_cnt; m_tag_cnt = m_tag_cnt + 4'd1;
    end else if (m_vld && rdy) begin
      m_vld = 0;
    end
    if (drop) m_ovr = 1;
    else if (clr) m_ovr = 0;
    if (!m_run) begin
      if (en) begin m_run = 1; m_phase = 0; end
    end else if (m_phase == FL + GAP) begin
      if (en) m_phase = 0; else m_run = 0;
    end else begin
      m_phase++;
    end
  endtask

  int         en_pct = 0, rdy_pct = 0, clr_pct = 0, rst_pm = 1000;
  bit         rdy_on_comp = 0;
  logic [3:0] tbl[$];

  task automatic push_word(input logic [15:0] w);
    tbl.push_back(w[15:12]); tbl.push_back(w[11:8]);
    tbl.push_back(w[7:4]);   tbl.push_back(w[3:0]);
  endtask

  task automatic step();
    bit cap, comp;
    logic [3:0] exp_tag;
    @(negedge data_clk);
`ifdef DESER_SEQ_TAG_EN
    exp_tag = m_tag;
`else
    exp_tag = 4'h0;
`endif
    chk("read", read, (m_run && m_phase == 0));
    chk("busy", busy, m_run);
    chk("word_valid", word_valid, m_vld);
    chk("overrun", overrun, m_ovr);
    chk("word_out", word_out, m_word);
    chk("word_tag", word_tag, exp_tag);
    cap  = m_run && m_phase == FL;
    comp = cap && (m_nibs.size() == N - 1);
    rst       = ($urandom_range(999) < rst_pm);
    enable    = ($urandom_range(99) < en_pct);
    clear_ovr = ($urandom_range(99) < clr_pct);
    out_ready = rdy_on_comp ? comp : ($urandom_range(99) < rdy_pct);
    de_out    = (cap && tbl.size() > 0) ? tbl.pop_front() : 4'($urandom);
    model_step(enable, de_out, out_ready, clear_ovr, rst);
  endtask

  task automatic run_until_words_done(input string tag);
    for (int i = 0; i < 1000 && (tbl.size() != 0 || m_nibs.size() != 0); i++) step();
    chk(tag, (tbl.size() == 0 && m_nibs.size() == 0), 1);
  endtask

  task automatic settle();
    @(posedge data_clk); #1;
  endtask

  initial begin
    model_step(0, 4'h0, 0, 0, 1);
    repeat (3) step();
    rst_pm = 0;
    settle();
    chk("rst_valid", word_valid, 0);
    chk("rst_word", word_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_read", read, 0);
    chk("rst_ovr", overrun, 0);

    // Basic frame sequence, word held until accepted
    en_pct = 100; rdy_pct = 0;
    push_word(16'hABCD);
    run_until_words_done("basic_to");
    settle();
    chk("basic_word", word_out, 16'hABCD);
    chk("basic_valid", word_valid, 1);

    // Backpressure overrun and clear
    rdy_pct = 100; step(); rdy_pct = 0;
    push_word(16'h1234); push_word(16'h5678);
    run_until_words_done("ovr_to");
    settle();
    chk("ovr_word", word_out, 16'h1234);
    chk("ovr_flag", overrun, 1);
    clr_pct = 100; step(); clr_pct = 0;
    settle();
    chk("clr_flag", overrun, 0);
    chk("clr_word", word_out, 16'h1234);

    // Accept in the same cycle a new word completes
    rdy_pct = 100; step(); rdy_pct = 0;
    rdy_on_comp = 1;
    push_word(16'h5555); push_word(16'h9ABC);
    run_until_words_done("simul_to");
    rdy_on_comp = 0;
    settle();
    chk("simul_word", word_out, 16'h9ABC);
    chk("simul_valid", word_valid, 1);
    chk("simul_ovr", overrun, 0);

    // Enable dropped at slot 5 of the second frame of a word
    rdy_pct = 100; step(); rdy_pct = 0;
    push_word(16'h2468);
    for (int i = 0; i < 200 && !(m_run && m_nibs.size() == 1 && m_phase == 6); i++) step();
    chk("drop_to", (m_run && m_nibs.size() == 1 && m_phase == 6), 1);
    en_pct = 0;
    repeat (40) step();
    settle();
    chk("drop_busy", busy, 0);
    chk("drop_valid", word_valid, 0);
    en_pct = 100;
    run_until_words_done("reen_to");
    settle();
    chk("reen_word", word_out, 16'h2468);

    // Reset at slot 8 after three captured nibbles
    rdy_pct = 100; step(); rdy_pct = 0;
    tbl.push_back(4'hE); tbl.push_back(4'hE); tbl.push_back(4'hE);
    for (int i = 0; i < 200 && !(m_run && m_nibs.size() == 3 && m_phase == 9); i++) step();
    chk("mrst_to", (m_run && m_nibs.size() == 3 && m_phase == 9), 1);
    rst_pm = 1000; step(); rst_pm = 0;
    settle();
    chk("mrst_valid", word_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_word", word_out, 0);
    push_word(16'hC0DE);
    run_until_words_done("fresh_to");
    settle();
    chk("fresh_word", word_out, 16'hC0DE);

    // Randomized traffic
    en_pct = 95; rdy_pct = 40; clr_pct = 5; rst_pm = 2;
    repeat (4000) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
